// File: rtl/mf_peak_trigger_pkg.sv
// Shared types and constants for the matched-filter peak trigger.
// The record layout is sized by the default sample geometry below.
package mf_peak_trigger_pkg;

    localparam int unsigned MF_NBITS  = 18;
    localparam int unsigned MF_NSAMPS = 8;
    localparam int unsigned MF_IDX_W  = 3;
    localparam int unsigned MF_POS_W  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StPeak,
        StReport,
        StHoldoff
    } state_e;

    typedef struct packed {
        logic [31:0]         tstamp;
        logic [MF_IDX_W-1:0] index;
        logic [MF_NBITS-1:0] peak;
        logic [MF_POS_W-1:0] pos;
    } rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ssr_abs_max.sv
// Two-stage SSR lane reducer: S1 magnitudes, S2 threshold flag, first index,
// beat maximum and the lowest lane index attaining that maximum.
module ssr_abs_max #(
    parameter int unsigned NBITS  = 18,
    parameter int unsigned NSAMPS = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NBITS*NSAMPS-1:0] data_i,
    input  logic [NBITS-2:0]        thresh_i,
    input  logic [31:0]             time_i,
    output logic                    any_o,
    output logic [IDX_W-1:0]        first_idx_o,
    output logic [NBITS-1:0]        max_o,
    output logic [IDX_W-1:0]        max_idx_o,
    output logic [31:0]             time_o
);

    logic [NBITS-1:0] r_mag [NSAMPS];
    logic [31:0]      r_time1;
    logic             r_any;
    logic [IDX_W-1:0] r_first;
    logic [NBITS-1:0] r_max;
    logic [IDX_W-1:0] r_max_idx;
    logic [31:0]      r_time2;

    logic             w_any;
    logic [IDX_W-1:0] w_first;
    logic [NBITS-1:0] w_max;
    logic [IDX_W-1:0] w_max_idx;

    // Two's-complement negate in NBITS unsigned: the most negative code maps to 2^(NBITS-1).
    function automatic logic [NBITS-1:0] abs_mag(input logic [NBITS-1:0] x);
        return x[NBITS-1] ? (~x + NBITS'(1)) : x;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NSAMPS; i++) r_mag[i] <= '0;
            r_time1 <= '0;
        end else begin
            for (int i = 0; i < NSAMPS; i++) r_mag[i] <= abs_mag(data_i[i*NBITS +: NBITS]);
            r_time1 <= time_i;
        end
    end

    always_comb begin
        w_any     = 1'b0;
        w_first   = '0;
        w_max     = '0;
        w_max_idx = '0;
        for (int i = NSAMPS - 1; i >= 0; i--) begin
            if (r_mag[i] > {1'b0, thresh_i}) begin
                w_any   = 1'b1;
                w_first = IDX_W'(i);
            end
        end
        // Strict compare keeps the lowest lane on ties.
        for (int i = 0; i < NSAMPS; i++) begin
            if (r_mag[i] > w_max) begin
                w_max     = r_mag[i];
                w_max_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_any     <= 1'b0;
            r_first   <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_time2   <= '0;
        end else begin
            r_any     <= w_any;
            r_first   <= w_first;
            r_max     <= w_max;
            r_max_idx <= w_max_idx;
            r_time2   <= r_time1;
        end
    end

    assign any_o       = r_any;
    assign first_idx_o = r_first;
    assign max_o       = r_max;
    assign max_idx_o   = r_max_idx;
    assign time_o      = r_time2;

endmodule

// File: rtl/mf_peak_trigger.sv
// Threshold trigger with windowed peak search, valid/ready record output,
// post-report holdoff and a saturating count of crossings missed while busy.
module mf_peak_trigger
    import mf_peak_trigger_pkg::*;
#(
    parameter int unsigned NBITS     = MF_NBITS,
    parameter int unsigned NSAMPS    = MF_NSAMPS,
    parameter int unsigned PEAK_CLKS = 4,
    parameter int unsigned HOLD_BITS = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NBITS*NSAMPS-1:0] data_i,
    input  logic                    arm_i,
    input  logic [NBITS-2:0]        thresh_i,
    input  logic [HOLD_BITS-1:0]    holdoff_i,
    output logic                    trig_valid_o,
    input  logic                    trig_ready_i,
    output logic [31:0]             trig_time_o,
    output logic [2:0]              trig_index_o,
    output logic [NBITS-1:0]        trig_peak_o,
    output logic [5:0]              trig_peak_pos_o,
    output logic [15:0]             missed_o,
    output logic                    busy_o
);

    localparam int unsigned IW    = MF_IDX_W;
    localparam int unsigned CNT_W = (PEAK_CLKS > 1) ? $clog2(PEAK_CLKS) : 1;

    state_e                r_state, w_state_d;
    logic [31:0]           r_beat;
    logic [NBITS-2:0]      r_thresh, w_thresh_d;
    logic [HOLD_BITS-1:0]  r_holdoff, w_holdoff_d;
    logic [HOLD_BITS-1:0]  r_hcnt, w_hcnt_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic [IW-1:0]         r_off, w_off_d;
    logic [15:0]           r_missed, w_missed_d;
    rec_t                  r_work, w_work_d;
    rec_t                  r_rec, w_rec_d;

    logic                  w_any;
    logic [IW-1:0]         w_first;
    logic [NBITS-1:0]      w_max;
    logic [IW-1:0]         w_max_idx;
    logic [31:0]           w_time;

    ssr_abs_max #(
        .NBITS  (NBITS),
        .NSAMPS (NSAMPS),
        .IDX_W  (IW)
    ) u_ssr (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .data_i      (data_i),
        .thresh_i    (r_thresh),
        .time_i      (r_beat),
        .any_o       (w_any),
        .first_idx_o (w_first),
        .max_o       (w_max),
        .max_idx_o   (w_max_idx),
        .time_o      (w_time)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat    <= '0;
            r_state   <= StIdle;
            r_thresh  <= '0;
            r_holdoff <= '0;
            r_hcnt    <= '0;
            r_cnt     <= '0;
            r_off     <= '0;
            r_missed  <= '0;
            r_work    <= '0;
            r_rec     <= '0;
        end else begin
            r_beat    <= r_beat + 32'd1;
            r_state   <= w_state_d;
            r_thresh  <= w_thresh_d;
            r_holdoff <= w_holdoff_d;
            r_hcnt    <= w_hcnt_d;
            r_cnt     <= w_cnt_d;
            r_off     <= w_off_d;
            r_missed  <= w_missed_d;
            r_work    <= w_work_d;
            r_rec     <= w_rec_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_thresh_d  = r_thresh;
        w_holdoff_d = r_holdoff;
        w_hcnt_d    = r_hcnt;
        w_cnt_d     = r_cnt;
        w_off_d     = r_off;
        w_missed_d  = r_missed;
        w_work_d    = r_work;
        w_rec_d     = r_rec;

        case (r_state)
            StIdle: begin
                if (arm_i) begin
                    w_thresh_d  = thresh_i;
                    w_holdoff_d = holdoff_i;
                    w_missed_d  = '0;
                    w_state_d   = StArmed;
                end
            end
            StArmed: begin
                if (!arm_i) begin
                    w_state_d = StIdle;
                end else if (w_any) begin
                    w_work_d.tstamp = w_time;
                    w_work_d.index  = w_first;
                    w_work_d.peak   = w_max;
                    w_work_d.pos    = {{(MF_POS_W - IW){1'b0}}, w_max_idx};
                    w_cnt_d         = CNT_W'(PEAK_CLKS - 1);
                    w_off_d         = IW'(1);
                    w_state_d       = (PEAK_CLKS == 1) ? StReport : StPeak;
                end
            end
            StPeak: begin
                if (w_max > r_work.peak) begin
                    w_work_d.peak = w_max;
                    w_work_d.pos  = {r_off, w_max_idx};
                end
                w_off_d = r_off + IW'(1);
                w_cnt_d = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) w_state_d = StReport;
            end
            StReport: begin
                if (w_any) w_missed_d = sat_inc16(r_missed);
                if (trig_ready_i) begin
                    if (r_holdoff == '0) begin
                        w_state_d = arm_i ? StArmed : StIdle;
                    end else begin
                        w_hcnt_d  = r_holdoff;
                        w_state_d = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (w_any) w_missed_d = sat_inc16(r_missed);
                if (r_hcnt <= HOLD_BITS'(1)) begin
                    w_state_d = arm_i ? StArmed : StIdle;
                end else begin
                    w_hcnt_d = r_hcnt - HOLD_BITS'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Publish only on entry to REPORT so the outputs hold between reports.
        if (w_state_d == StReport && r_state != StReport) w_rec_d = w_work_d;
    end

    assign trig_valid_o    = (r_state == StReport);
    assign busy_o          = (r_state != StIdle) && (r_state != StArmed);
    assign trig_time_o     = r_rec.tstamp;
    assign trig_index_o    = r_rec.index;
    assign trig_peak_o     = r_rec.peak;
    assign trig_peak_pos_o = r_rec.pos;
    assign missed_o        = r_missed;

endmodule

// File: tb/tb_mf_peak_trigger.sv
// Directed bench for mf_peak_trigger: expected records are queued as crossings
// are driven and popped when the DUT presents a trigger.
module tb_mf_peak_trigger;
    import mf_peak_trigger_pkg::*;

    localparam int NB = 18;
    localparam int NS = 8;

    logic           aclk;
    logic           aresetn;
    logic [NB*NS-1:0] data_i;
    logic           arm_i;
    logic [NB-2:0]  thresh_i;
    logic [15:0]    holdoff_i;
    logic           trig_valid_o;
    logic           trig_ready_i;
    logic [31:0]    trig_time_o;
    logic [2:0]     trig_index_o;
    logic [NB-1:0]  trig_peak_o;
    logic [5:0]     trig_peak_pos_o;
    logic [15:0]    missed_o;
    logic           busy_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] tb_beat = 0;
    rec_t        sb[$];

    mf_peak_trigger dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .data_i          (data_i),
        .arm_i           (arm_i),
        .thresh_i        (thresh_i),
        .holdoff_i       (holdoff_i),
        .trig_valid_o    (trig_valid_o),
        .trig_ready_i    (trig_ready_i),
        .trig_time_o     (trig_time_o),
        .trig_index_o    (trig_index_o),
        .trig_peak_o     (trig_peak_o),
        .trig_peak_pos_o (trig_peak_pos_o),
        .missed_o        (missed_o),
        .busy_o          (busy_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input rec_t e);
        check({tag, "_time"},  trig_time_o,     e.tstamp);
        check({tag, "_index"}, trig_index_o,    e.index);
        check({tag, "_peak"},  trig_peak_o,     e.peak);
        check({tag, "_pos"},   trig_peak_pos_o, e.pos);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        tb_beat++;
    endtask

    task automatic drive_beat(input int idx, input int val);
        data_i = '0;
        data_i[idx*NB +: NB] = NB'(val);
        tick();
        data_i = '0;
    endtask

    task automatic push_exp(input logic [31:0] t, input int idx, input int pk, input int pos);
        rec_t r;
        r.tstamp = t;
        r.index  = 3'(idx);
        r.peak   = NB'(pk);
        r.pos    = 6'(pos);
        sb.push_back(r);
    endtask

    // Wait for a record, compare it with the queue head, hold ready low for
    // `hold` clocks (driving `miss` crossing beats of value mval), then accept.
    task automatic wait_report(input int hold, input int miss, input int mval);
        rec_t e;
        int   k;
        k = 0;
        while (!trig_valid_o && k < 60) begin
            tick();
            k++;
        end
        check("valid_seen", trig_valid_o, 1'b1);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check_rec("rec", e);
        for (int i = 0; i < hold; i++) begin
            if (i < miss) drive_beat(0, mval);
            else tick();
            check("valid_hold", trig_valid_o, 1'b1);
            check_rec("rec_hold", e);
        end
        trig_ready_i = 1'b1;
        tick();
        trig_ready_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 80) begin
            tick();
            k++;
        end
        check("idle_reached", busy_o, 1'b0);
    endtask

    initial begin
        logic [31:0] t;
        int          n;

        aresetn      = 1'b0;
        data_i       = '0;
        arm_i        = 1'b0;
        thresh_i     = '0;
        holdoff_i    = '0;
        trig_ready_i = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_valid",  trig_valid_o, 1'b0);
        check("rst_busy",   busy_o, 1'b0);
        check("rst_missed", missed_o, 16'd0);
        check("rst_time",   trig_time_o, 32'd0);
        check("rst_peak",   trig_peak_o, 18'd0);
        aresetn = 1'b1;
        tb_beat = 0;

        // Single crossing on a negative sample at beat 100.
        thresh_i  = 17'd1000;
        holdoff_i = 16'd0;
        arm_i     = 1'b1;
        tick();
        while (tb_beat < 100) tick();
        push_exp(tb_beat, 5, 1500, 8'h05);
        drive_beat(5, -1500);
        wait_report(0, 0, 0);
        tick();
        check("a_busy_after", busy_o, 1'b0);

        // Later larger peak wins; an equal peak later in the window does not move it.
        tick();
        t = tb_beat;
        push_exp(t, 2, 3000, 8'h17);
        drive_beat(2, 1001);
        tick();
        drive_beat(7, 3000);
        drive_beat(1, 3000);
        wait_report(0, 0, 0);

        // Stalled ready, crossings while busy, 20-clock holdoff.
        arm_i = 1'b0;
        tick();
        tick();
        holdoff_i = 16'd20;
        arm_i     = 1'b1;
        repeat (3) tick();
        t = tb_beat;
        push_exp(t, 3, 2000, 8'h03);
        drive_beat(3, 2000);
        wait_report(10, 5, 5000);
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            tick();
        end
        check("holdoff_len", n, 20);
        check("missed_5", missed_o, 16'd5);
        t = tb_beat;
        push_exp(t, 6, 1800, 8'h06);
        drive_beat(6, 1800);
        wait_report(0, 0, 0);
        arm_i = 1'b0;
        wait_idle();

        // Most negative code against the largest threshold; equality never triggers.
        thresh_i  = 17'd131071;
        holdoff_i = 16'd0;
        arm_i     = 1'b1;
        repeat (3) tick();
        t = tb_beat;
        push_exp(t, 4, 131072, 8'h04);
        drive_beat(4, -131072);
        wait_report(0, 0, 0);
        drive_beat(0, 131071);
        drive_beat(5, -131071);
        repeat (10) tick();
        check("eq_no_valid", trig_valid_o, 1'b0);
        check("eq_no_busy",  busy_o, 1'b0);

        // Drop arm during PEAK: report completes, then IDLE; re-arm relatches.
        t = tb_beat;
        push_exp(t, 1, 131072, 8'h01);
        drive_beat(1, -131072);
        n = 0;
        while (!busy_o && n < 10) begin
            tick();
            n++;
        end
        check("e_in_peak", busy_o, 1'b1);
        arm_i = 1'b0;
        wait_report(3, 2, -131072);
        tick();
        check("e_idle_busy", busy_o, 1'b0);
        check("e_missed_2",  missed_o, 16'd2);
        drive_beat(4, -131072);
        repeat (6) tick();
        check("e_idle_no_trig", trig_valid_o, 1'b0);
        thresh_i = 17'd500;
        arm_i    = 1'b1;
        tick();
        check("e_missed_clr", missed_o, 16'd0);
        repeat (2) tick();
        t = tb_beat;
        push_exp(t, 3, 600, 8'h03);
        drive_beat(3, 600);
        wait_report(0, 0, 0);

        // Asynchronous reset while a record is pending.
        tick();
        drive_beat(2, 700);
        n = 0;
        while (!trig_valid_o && n < 30) begin
            tick();
            n++;
        end
        check("r_valid_before", trig_valid_o, 1'b1);
        drive_beat(0, 900);
        repeat (3) tick();
        check("r_missed_before", missed_o, 16'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("r_valid",  trig_valid_o, 1'b0);
        check("r_busy",   busy_o, 1'b0);
        check("r_missed", missed_o, 16'd0);
        check("r_time",   trig_time_o, 32'd0);
        check("r_pos",    trig_peak_pos_o, 6'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tb_beat = 0;
        tick();
        check("r_post_busy", busy_o, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
